// File: rtl/aes128_ks_ctrl_if.sv
// Control bus between the AES-128 key-schedule sequencer and its surroundings.
// The abort signal exists only when KS_ABORT_EN is defined.
interface aes128_ks_ctrl_if #(
  parameter int d = 2
);
  logic           start;
  logic           busy;
  logic           key_sel;
  logic           key_reg_en;
  logic [8*d-1:0] sh_RCON;
  logic           rk_valid;
  logic [3:0]     rk_idx;
  logic           done;
`ifdef KS_ABORT_EN
  logic           abort;
`endif

  modport master (
    input  start,
`ifdef KS_ABORT_EN
    input  abort,
`endif
    output busy, key_sel, key_reg_en, sh_RCON, rk_valid, rk_idx, done
  );

  modport slave (
    output start,
`ifdef KS_ABORT_EN
    output abort,
`endif
    input  busy, key_sel, key_reg_en, sh_RCON, rk_valid, rk_idx, done
  );
endinterface

// File: rtl/aes128_ks_ctrl.sv
// Sequencer for a masked AES-128 key-schedule round datapath (d shares, LATENCY-cycle rounds).
// Optional feature: define KS_ABORT_EN to add the abort input.
module aes128_ks_ctrl #(
  parameter int d       = 2,
  parameter int LATENCY = 6
) (
  input  logic              clk,
  input  logic              rst,
  aes128_ks_ctrl_if.master  ks
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  state_t         state;
  logic [3:0]     round;
  logic [CW-1:0]  cnt;
  logic [7:0]     rcon;
  logic           busy_r;
  logic           rk_valid_r;
  logic [3:0]     rk_idx_r;
  logic           done_r;
  logic           abort_i;
  logic           capture;
  logic [8*d-1:0] rcon_sh;

`ifdef KS_ABORT_EN
  assign abort_i = ks.abort;
`else
  assign abort_i = 1'b0;
`endif

  assign capture = (state == ROUND) && (cnt == CNT_LAST);

  // Share 0 of every RCON bit carries the constant, remaining shares are zero.
  always_comb begin
    rcon_sh = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      rcon_sh[b*d] = rcon[b];
    end
  end

  always_comb begin
    ks.key_sel    = 1'b0;
    ks.key_reg_en = 1'b0;
    ks.sh_RCON    = '0;
    case (state)
      IDLE: begin
        ks.key_sel    = 1'b1;
        ks.key_reg_en = ks.start;
      end
      ROUND: begin
        if (capture) begin
          ks.sh_RCON = rcon_sh;
          if (!abort_i) begin
            ks.key_reg_en = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      round      <= '0;
      cnt        <= '0;
      rcon       <= 8'h01;
      busy_r     <= 1'b0;
      rk_valid_r <= 1'b0;
      rk_idx_r   <= '0;
      done_r     <= 1'b0;
    end else begin
      rk_valid_r <= 1'b0;
      done_r     <= 1'b0;
      case (state)
        IDLE: begin
          if (ks.start) begin
            state      <= ROUND;
            round      <= 4'd1;
            cnt        <= '0;
            rcon       <= 8'h01;
            busy_r     <= 1'b1;
            rk_valid_r <= 1'b1;
            rk_idx_r   <= '0;
          end
        end
        ROUND: begin
          if (abort_i) begin
            state  <= IDLE;
            round  <= '0;
            cnt    <= '0;
            rcon   <= 8'h01;
            busy_r <= 1'b0;
          end else if (capture) begin
            cnt        <= '0;
            rcon       <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00);
            rk_valid_r <= 1'b1;
            rk_idx_r   <= round;
            if (round == 4'd10) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              round <= round + 4'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          round  <= '0;
          cnt    <= '0;
          rcon   <= 8'h01;
          busy_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ks.busy     = busy_r;
  assign ks.rk_valid = rk_valid_r;
  assign ks.rk_idx   = rk_idx_r;
  assign ks.done     = done_r;
endmodule

// File: tb/tb_aes128_ks_ctrl.sv
// Directed self-checking bench for aes128_ks_ctrl (LATENCY 6 and LATENCY 2 instances).
module tb_aes128_ks_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] rc_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  aes128_ks_ctrl_if #(.d(2)) bus6 ();
  aes128_ks_ctrl_if #(.d(2)) bus2 ();

  aes128_ks_ctrl #(.d(2), .LATENCY(6)) dut6 (.clk(clk), .rst(rst), .ks(bus6.master));
  aes128_ks_ctrl #(.d(2), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .ks(bus2.master));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] shr(input logic [7:0] v);
    logic [15:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) r[2*b] = v[b];
    return r;
  endfunction

  initial begin
    logic [15:0] exp_rc;
    bus6.start = 1'b0;
    bus2.start = 1'b0;
`ifdef KS_ABORT_EN
    bus6.abort = 1'b0;
    bus2.abort = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;

    // reset / idle
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_busy",    32'(bus6.busy),       32'd0);
      chk("idle_key_sel", 32'(bus6.key_sel),    32'd1);
      chk("idle_en",      32'(bus6.key_reg_en), 32'd0);
      chk("idle_rcon",    32'(bus6.sh_RCON),    32'd0);
      chk("idle_valid",   32'(bus6.rk_valid),   32'd0);
      chk("idle_idx",     32'(bus6.rk_idx),     32'd0);
      chk("idle_done",    32'(bus6.done),       32'd0);
    end

    // full run, single start pulse
    for (int c = 0; c <= 62; c++) begin
      tick();
      bus6.start = (c == 0);
      #1;
      exp_rc = (c >= 6 && c <= 60 && c % 6 == 0) ? shr(rc_tbl[c/6-1]) : 16'h0;
      chk("run_en",    32'(bus6.key_reg_en), 32'((c % 6 == 0) && (c <= 60)));
      chk("run_rcon",  32'(bus6.sh_RCON),    32'(exp_rc));
      chk("run_valid", 32'(bus6.rk_valid),   32'((c >= 1) && (c <= 61) && ((c - 1) % 6 == 0)));
      if (c >= 1 && c <= 61 && (c - 1) % 6 == 0)
        chk("run_idx", 32'(bus6.rk_idx), 32'((c - 1) / 6));
      chk("run_done",  32'(bus6.done),       32'(c == 61));
      chk("run_busy",  32'(bus6.busy),       32'((c >= 1) && (c <= 61)));
      if ((c % 6 == 0) && (c >= 6) && (c <= 60))
        chk("run_ksel", 32'(bus6.key_sel), 32'd0);
    end

    // start held high: back-to-back runs, 62-cycle spacing
    for (int c = 0; c <= 81; c++) begin
      tick();
      bus6.start = 1'b1;
      #1;
      chk("hold_en", 32'(bus6.key_reg_en),
          32'(((c % 6 == 0) && (c <= 60)) || ((c >= 62) && ((c - 62) % 6 == 0))));
      if (c == 63) begin
        chk("hold_idx",   32'(bus6.rk_idx),   32'd0);
        chk("hold_valid", 32'(bus6.rk_valid), 32'd1);
        chk("hold_busy",  32'(bus6.busy),     32'd1);
      end
    end

    // asynchronous reset at T2+20 of the second run
    tick();
    bus6.start = 1'b0;
    #1;
    chk("pre_rst_busy", 32'(bus6.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_busy",  32'(bus6.busy),       32'd0);
    chk("rst_valid", 32'(bus6.rk_valid),   32'd0);
    chk("rst_done",  32'(bus6.done),       32'd0);
    chk("rst_idx",   32'(bus6.rk_idx),     32'd0);
    chk("rst_en",    32'(bus6.key_reg_en), 32'd0);
    chk("rst_rcon",  32'(bus6.sh_RCON),    32'd0);
    chk("rst_ksel",  32'(bus6.key_sel),    32'd1);
    tick();
    rst = 1'b0;

    for (int c = 0; c <= 62; c++) begin
      tick();
      bus6.start = (c == 0);
      #1;
      if (c == 0) chk("re_en0", 32'(bus6.key_reg_en), 32'd1);
      if (c == 1) begin
        chk("re_idx0",   32'(bus6.rk_idx),   32'd0);
        chk("re_valid0", 32'(bus6.rk_valid), 32'd1);
      end
      if (c == 6) begin
        chk("re_rcon1", 32'(bus6.sh_RCON),    32'(shr(8'h01)));
        chk("re_en1",   32'(bus6.key_reg_en), 32'd1);
      end
      if (c == 7)  chk("re_idx1", 32'(bus6.rk_idx), 32'd1);
      if (c == 61) chk("re_done", 32'(bus6.done),   32'd1);
      if (c == 62) chk("re_busy", 32'(bus6.busy),   32'd0);
    end

    // LATENCY = 2 instance
    for (int c = 0; c <= 22; c++) begin
      tick();
      bus2.start = (c == 0);
      #1;
      exp_rc = (c >= 2 && c <= 20 && c % 2 == 0) ? shr(rc_tbl[c/2-1]) : 16'h0;
      chk("l2_en",   32'(bus2.key_reg_en), 32'((c % 2 == 0) && (c <= 20)));
      chk("l2_rcon", 32'(bus2.sh_RCON),    32'(exp_rc));
      chk("l2_done", 32'(bus2.done),       32'(c == 21));
      chk("l2_busy", 32'(bus2.busy),       32'((c >= 1) && (c <= 21)));
      if (c == 21) chk("l2_idx", 32'(bus2.rk_idx), 32'd10);
    end

`ifdef KS_ABORT_EN
    // abort on the capture cycle T+30
    for (int c = 0; c <= 34; c++) begin
      tick();
      bus6.start = (c == 0);
      bus6.abort = (c == 30);
      #1;
      chk("ab_en", 32'(bus6.key_reg_en), 32'((c % 6 == 0) && (c < 30)));
      chk("ab_done", 32'(bus6.done), 32'd0);
      if (c >= 31) begin
        chk("ab_busy", 32'(bus6.busy),    32'd0);
        chk("ab_ksel", 32'(bus6.key_sel), 32'd1);
      end
    end
    bus6.abort = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
